// File: rtl/mem_readin_pkg.sv
// Shared types and constants for the residual read-in router: seeding modes,
// default widths, and the route/tracklet-index classes used by the decode tables.
package mem_readin_pkg;

  typedef enum logic [1:0] {
    SEED_LAYER  = 2'd0,
    SEED_DISK   = 2'd1,
    SEED_HYBRID = 2'd2
  } seeding_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_N_MEM   = 17;
  localparam int DEF_DATA_W  = 40;
  localparam int DEF_ROUTE_W = 5;
  localparam int DEF_IDX_W   = 4;
  localparam int DEF_ADDR_W  = 6;
  localparam int DEF_BX_W    = 4;
  localparam int DROP_W      = 8;

  // tracklet-index classes
  localparam int IDX_F1F2     = 7;
  localparam int IDX_F1L1     = 6;
  localparam int IDX_L1L2_MAX = 2;
  localparam int IDX_L3L4_MAX = 5;

  // route codes
  localparam int ROUTE_L_DIRECT_MAX = 8;
  localparam int ROUTE_L_SPLIT_LO   = 9;
  localparam int ROUTE_L_SPLIT_HI   = 10;
  localparam int ROUTE_L_TAIL_LO    = 11;
  localparam int ROUTE_L_TAIL_HI    = 12;
  localparam int ROUTE_F1F2_MAX     = 6;

endpackage

// File: rtl/mem_readin_router_decode.sv
// Combinational route decode: (seeding mode, route code, tracklet index) -> target
// match memory. Entries that land at or beyond N_MEM are reported as no hit.
module mem_readin_router_decode
  import mem_readin_pkg::*;
#(
  parameter seeding_e SEEDING = SEED_LAYER,
  parameter int N_MEM   = DEF_N_MEM,
  parameter int ROUTE_W = DEF_ROUTE_W,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int SEL_W   = (N_MEM > 1) ? $clog2(N_MEM) : 1
) (
  input  logic [ROUTE_W-1:0] route,
  input  logic [IDX_W-1:0]   idx,
  output logic               hit,
  output logic [SEL_W-1:0]   mem_sel
);

  int r, x, tgt;

  always_comb begin
    r   = int'(route);
    x   = int'(idx);
    tgt = -1;
    case (SEEDING)
      SEED_LAYER: begin
        if (r >= 1 && r <= ROUTE_L_DIRECT_MAX)
          tgt = r - 1;
        else if (r == ROUTE_L_SPLIT_LO || r == ROUTE_L_SPLIT_HI)
          tgt = (x == IDX_F1F2) ? r + 3 : r - 1;
        else if (r >= ROUTE_L_TAIL_LO && r <= ROUTE_L_TAIL_HI)
          tgt = r - 1;
      end
      SEED_DISK: begin
        if (x == IDX_F1F2) begin
          if (r >= 1 && r <= ROUTE_F1F2_MAX) tgt = r - 1;
        end else if (x == IDX_F1L1) begin
          case (r)
            5: tgt = 6;
            1: tgt = 7;
            2: tgt = 8;
            3: tgt = 9;
            default: tgt = -1;
          endcase
        end else if (x <= IDX_L1L2_MAX) begin
          case (r)
            4: tgt = 10;
            5: tgt = 11;
            1: tgt = 12;
            2: tgt = 13;
            6: tgt = 14;
            default: tgt = -1;
          endcase
        end else if (x <= IDX_L3L4_MAX) begin
          case (r)
            4: tgt = 15;
            5: tgt = 16;
            default: tgt = -1;
          endcase
        end
      end
      default: begin
        if (x <= IDX_L1L2_MAX) begin
          case (r)
            4: tgt = 0;
            5: tgt = 1;
            1: tgt = 2;
            2: tgt = 3;
            default: tgt = -1;
          endcase
        end else if (x <= IDX_L3L4_MAX) begin
          case (r)
            4: tgt = 4;
            5: tgt = 5;
            default: tgt = -1;
          endcase
        end else if (x == IDX_F1F2) begin
          if (r >= 1 && r <= ROUTE_F1F2_MAX) tgt = r + 5;
        end else if (x == IDX_F1L1) begin
          case (r)
            5: tgt = 12;
            1: tgt = 13;
            2: tgt = 14;
            3: tgt = 15;
            default: tgt = -1;
          endcase
        end
      end
    endcase
  end

  assign hit     = (tgt >= 0) && (tgt < N_MEM);
  assign mem_sel = hit ? SEL_W'(tgt) : '0;

endmodule

// File: rtl/mem_readin_router.sv
// Steers residual words from the FIFO into N_MEM match memories, with per-memory
// write addresses that restart at each BX, sticky overflow flags and a drop counter.
module mem_readin_router
  import mem_readin_pkg::*;
#(
  parameter seeding_e SEEDING = SEED_LAYER,
  parameter int N_MEM   = DEF_N_MEM,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ROUTE_W = DEF_ROUTE_W,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BX_W    = DEF_BX_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ROUTE_W+DATA_W-1:0] data_residuals,
  input  logic                      valid,
  output logic                      ready,
  input  logic                      start,
  input  logic [BX_W-1:0]           bx_in,
  output logic [DATA_W-1:0]         output_match,
  output logic [N_MEM-1:0]          wr_en,
  output logic [N_MEM*ADDR_W-1:0]   wr_addr,
  output logic [N_MEM-1:0]          overflow,
  output logic [DROP_W-1:0]         drop_cnt,
  output logic [BX_W-1:0]           output_BX,
  output logic                      send_BX
);

  localparam int SEL_W = (N_MEM > 1) ? $clog2(N_MEM) : 1;

  state_e                          state;
  logic                            accept, hit;
  logic [SEL_W-1:0]                mem_sel;
  logic [ROUTE_W-1:0]              route;
  logic [DATA_W-1:0]               payload;
  logic [IDX_W-1:0]                idx;
  logic [N_MEM-1:0][ADDR_W-1:0]    cnt, cnt_nxt, addr_cur;
  logic [N_MEM-1:0]                wr_nxt, ovf_nxt;
  logic [DROP_W-1:0]               drop_cur;

  assign route   = data_residuals[ROUTE_W+DATA_W-1 -: ROUTE_W];
  assign payload = data_residuals[DATA_W-1:0];
  assign idx     = payload[DATA_W-1 -: IDX_W];
  assign accept  = valid & ready;

  mem_readin_router_decode #(
    .SEEDING (SEEDING),
    .N_MEM   (N_MEM),
    .ROUTE_W (ROUTE_W),
    .IDX_W   (IDX_W),
    .SEL_W   (SEL_W)
  ) u_decode (
    .route   (route),
    .idx     (idx),
    .hit     (hit),
    .mem_sel (mem_sel)
  );

  // start zeroes the BX state combinationally so a word accepted alongside it
  // is the first word of the new BX.
  for (genvar i = 0; i < N_MEM; i++) begin : g_mem
    logic              sel, cur_ovf, full;
    logic [ADDR_W-1:0] cur_cnt;
    assign sel         = accept & hit & (mem_sel == SEL_W'(i));
    assign cur_cnt     = start ? '0 : cnt[i];
    assign cur_ovf     = start ? 1'b0 : overflow[i];
    assign full        = &cur_cnt;
    assign wr_nxt[i]   = sel & ~cur_ovf;
    assign addr_cur[i] = cur_cnt;
    assign cnt_nxt[i]  = (wr_nxt[i] & ~full) ? cur_cnt + 1'b1 : cur_cnt;
    assign ovf_nxt[i]  = cur_ovf | (wr_nxt[i] & full);
  end

  assign drop_cur = start ? '0 : drop_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_RUN;
          ready <= 1'b1;
        end
        ST_RUN:  ready <= 1'b1;
        default: begin
          state <= ST_IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      overflow     <= '0;
      wr_en        <= '0;
      wr_addr      <= '0;
      output_match <= '0;
      drop_cnt     <= '0;
      output_BX    <= '0;
      send_BX      <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      overflow <= ovf_nxt;
      wr_en    <= wr_nxt;
      send_BX  <= start;
      for (int i = 0; i < N_MEM; i++)
        if (wr_nxt[i]) wr_addr[i*ADDR_W +: ADDR_W] <= addr_cur[i];
      if (accept) output_match <= payload;
      if (start) output_BX <= bx_in;
      // overflowed-but-routed words are not counted as drops
      if (accept && !hit && drop_cur != '1) drop_cnt <= drop_cur + 1'b1;
      else                                  drop_cnt <= drop_cur;
    end
  end

endmodule

// File: tb/tb_mem_readin_router.sv
// Drives Layer, Disk and Hybrid instances with one stimulus stream; a queue-based
// scoreboard compares every cycle's outputs against a table-level reference model.
module tb_mem_readin_router;
  import mem_readin_pkg::*;

  localparam int N_MEM = 17, DATA_W = 40, ROUTE_W = 5, IDX_W = 4, ADDR_W = 3, BX_W = 4;
  localparam int NM = 3;
  localparam int DEPTH = 1 << ADDR_W;

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic [ROUTE_W+DATA_W-1:0] data_residuals = '0;
  logic                      valid = 1'b0;
  logic                      start = 1'b0;
  logic [BX_W-1:0]           bx_in = '0;

  logic                    rdy_a [NM];
  logic [DATA_W-1:0]       om_a  [NM];
  logic [N_MEM-1:0]        we_a  [NM];
  logic [N_MEM*ADDR_W-1:0] wa_a  [NM];
  logic [N_MEM-1:0]        ovf_a [NM];
  logic [7:0]              dc_a  [NM];
  logic [BX_W-1:0]         obx_a [NM];
  logic                    sbx_a [NM];

  for (genvar g = 0; g < NM; g++) begin : g_dut
    mem_readin_router #(
      .SEEDING (seeding_e'(g)),
      .N_MEM   (N_MEM),
      .DATA_W  (DATA_W),
      .ROUTE_W (ROUTE_W),
      .IDX_W   (IDX_W),
      .ADDR_W  (ADDR_W),
      .BX_W    (BX_W)
    ) dut (
      .clk            (clk),
      .reset          (reset),
      .data_residuals (data_residuals),
      .valid          (valid),
      .ready          (rdy_a[g]),
      .start          (start),
      .bx_in          (bx_in),
      .output_match   (om_a[g]),
      .wr_en          (we_a[g]),
      .wr_addr        (wa_a[g]),
      .overflow       (ovf_a[g]),
      .drop_cnt       (dc_a[g]),
      .output_BX      (obx_a[g]),
      .send_BX        (sbx_a[g])
    );
  end

  always #5 clk = ~clk;

  typedef struct {
    logic                               rdy;
    logic                               send;
    logic [BX_W-1:0]                    bx;
    logic [DATA_W-1:0]                  match;
    logic [NM-1:0][N_MEM-1:0]           we;
    logic [NM-1:0][N_MEM-1:0]           ovf;
    logic [NM-1:0][7:0]                 drop;
    logic [NM-1:0][N_MEM-1:0][ADDR_W-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int          m_cnt  [NM][N_MEM];
  bit          m_full [NM][N_MEM];
  int          m_drop [NM];
  bit          m_run;
  logic [BX_W-1:0]   m_bx;
  logic [DATA_W-1:0] m_match;

  // Table lookup: each (mode, idx class) has an ordered route list placed at a base memory.
  function automatic int tgt(input int m, input int r, input int x);
    int lst[$];
    int base;
    if (m == 0) begin
      if (r >= 1 && r <= 8)   return r - 1;
      if (r == 9 || r == 10)  return (x != 7) ? r - 1 : r + 3;
      if (r == 11 || r == 12) return r - 1;
      return -1;
    end
    base = -1;
    if (m == 1) begin
      if (x == 7)      begin lst = {1, 2, 3, 4, 5, 6}; base = 0;  end
      else if (x == 6) begin lst = {5, 1, 2, 3};       base = 6;  end
      else if (x <= 2) begin lst = {4, 5, 1, 2, 6};    base = 10; end
      else if (x <= 5) begin lst = {4, 5};             base = 15; end
    end else begin
      if (x <= 2)      begin lst = {4, 5, 1, 2};       base = 0;  end
      else if (x <= 5) begin lst = {4, 5};             base = 4;  end
      else if (x == 7) begin lst = {1, 2, 3, 4, 5, 6}; base = 6;  end
      else if (x == 6) begin lst = {5, 1, 2, 3};       base = 12; end
    end
    foreach (lst[k]) if (lst[k] == r) return (base + k < N_MEM) ? base + k : -1;
    return -1;
  endfunction

  task automatic step(input logic r, input logic s, input logic [BX_W-1:0] b,
                      input logic v, input logic [ROUTE_W-1:0] rt, input logic [IDX_W-1:0] ix);
    exp_t e;
    logic [DATA_W-IDX_W-1:0] lo;
    bit acc;
    int t;
    @(negedge clk);
    lo = {4'($urandom()), $urandom()};
    reset = r; start = s; bx_in = b; valid = v;
    data_residuals = {rt, ix, lo};
    e.we = '0; e.addr = '0;
    if (!r) begin
      m_run = 0; m_bx = '0; m_match = '0;
      for (int m = 0; m < NM; m++) begin
        m_drop[m] = 0;
        for (int i = 0; i < N_MEM; i++) begin m_cnt[m][i] = 0; m_full[m][i] = 0; end
      end
      e.send = 1'b0;
    end else begin
      acc = v && m_run;
      if (s) begin
        m_bx = b;
        for (int m = 0; m < NM; m++) begin
          m_drop[m] = 0;
          for (int i = 0; i < N_MEM; i++) begin m_cnt[m][i] = 0; m_full[m][i] = 0; end
        end
      end
      if (acc) m_match = data_residuals[DATA_W-1:0];
      for (int m = 0; m < NM; m++) begin
        if (acc) begin
          t = tgt(m, int'(rt), int'(ix));
          if (t < 0) begin
            if (m_drop[m] < 255) m_drop[m]++;
          end else if (!m_full[m][t]) begin
            e.we[m][t]   = 1'b1;
            e.addr[m][t] = ADDR_W'(m_cnt[m][t]);
            if (m_cnt[m][t] == DEPTH - 1) m_full[m][t] = 1;
            else m_cnt[m][t]++;
          end
        end
      end
      if (s) m_run = 1;
      e.send = s;
    end
    e.rdy = m_run; e.bx = m_bx; e.match = m_match;
    for (int m = 0; m < NM; m++) begin
      e.drop[m] = 8'(m_drop[m]);
      for (int i = 0; i < N_MEM; i++) e.ovf[m][i] = m_full[m][i];
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s mode%0d t=%0t got=%h want=%h", nm, g, $time, act, req);
    end
  endtask

  // monitor: one expected record per clock edge, sampled just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        for (int g = 0; g < NM; g++) begin
          chk("ready",        g, 64'(rdy_a[g]), 64'(e.rdy));
          chk("wr_en",        g, 64'(we_a[g]),  64'(e.we[g]));
          chk("overflow",     g, 64'(ovf_a[g]), 64'(e.ovf[g]));
          chk("drop_cnt",     g, 64'(dc_a[g]),  64'(e.drop[g]));
          chk("output_BX",    g, 64'(obx_a[g]), 64'(e.bx));
          chk("send_BX",      g, 64'(sbx_a[g]), 64'(e.send));
          chk("output_match", g, 64'(om_a[g]),  64'(e.match));
          for (int i = 0; i < N_MEM; i++)
            if (e.we[g][i]) chk("wr_addr", g, 64'(wa_a[g][i*ADDR_W +: ADDR_W]), 64'(e.addr[g][i]));
        end
      end
    end
  end

  initial begin
    repeat (2) step(0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 1, 1, 0);          // valid without start: no accept
    step(1, 1, 3, 0, 0, 0);                     // start BX 3
    repeat (3) step(1, 0, 0, 1, 1, 0);
    step(1, 0, 0, 1, 9, 7);
    step(1, 0, 0, 1, 9, 2);
    step(1, 0, 0, 1, 13, 0);
    repeat (DEPTH + 1) step(1, 0, 0, 1, 4, 0);  // fill and overflow one memory
    repeat (5) step(1, 0, 0, 1, 2, 0);
    step(1, 1, 5, 1, 2, 0);                     // start with an accepted word
    step(1, 0, 0, 1, 4, 1);
    step(1, 0, 0, 1, 4, 4);
    step(1, 0, 0, 1, 4, 6);
    step(1, 0, 0, 1, 4, 7);
    step(1, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);                     // reset pulse mid-stream
    repeat (3) step(1, 0, 0, 1, 1, 0);
    step(1, 1, 9, 0, 0, 0);
    repeat (262) step(1, 0, 0, 1, 0, 0);        // drop counter saturation
    for (int n = 0; n < 2500; n++)
      step(1'($urandom_range(0, 499) != 0), 1'($urandom_range(0, 39) == 0),
           4'($urandom()), 1'($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
